jk_universal_register: RTL and testbench

- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit register bank with per-bit JK control.
- Adds parallel load, bidirectional serial shift, up/down counting with wrap-around, and bulk invert.
- Provides a terminal-count flag and a per-bit change-detect vector.
- Used as the general-purpose state/count element in TD1 sequential designs; replaces ad-hoc chains of single JK cells.

---
 rtl/jk_universal_register.sv | 110 +++++++++++
 tb/tb_jk_universal_register.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_universal_register.sv
// jk_universal_register
// WIDTH-bit register bank with per-bit JK control, parallel load,
// bidirectional serial shift, wrapping up/down count and bulk invert.
// Also provides a terminal-count flag and a registered per-bit
// change-detect vector that lines up with the Q it describes.
module jk_universal_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             Ck,
    input  logic             Reset,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             SerOut,
    output logic             Tc,
    output logic [WIDTH-1:0] Changed
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_JK   = 3'b001;
    localparam logic [2:0] MODE_LOAD = 3'b010;
    localparam logic [2:0] MODE_SHL  = 3'b011;
    localparam logic [2:0] MODE_SHR  = 3'b100;
    localparam logic [2:0] MODE_UP   = 3'b101;
    localparam logic [2:0] MODE_DOWN = 3'b110;
    localparam logic [2:0] MODE_INV  = 3'b111;

    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] changed_q;
    logic [WIDTH-1:0] changed_d;

    // Next-state selection: disabled cycles hold, otherwise the selected operation.
    always_comb begin
        q_d = q_q;
        if (En) begin
            case (Mode)
                MODE_HOLD: q_d = q_q;
                MODE_JK:   q_d = (J & ~q_q) | (~K & q_q);
                MODE_LOAD: q_d = D;
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], SerIn};
                MODE_SHR:  q_d = {SerIn, q_q[WIDTH-1:1]};
                MODE_UP:   q_d = q_q + ONE_VAL;
                MODE_DOWN: q_d = q_q - ONE_VAL;
                MODE_INV:  q_d = ~q_q;
                default:   q_d = q_q;
            endcase
        end else begin
            q_d = q_q;
        end
    end

    // Change-detect: only enabled edges report differences; idle edges clear it.
    always_comb begin
        changed_d = ZERO_VAL;
        if (En) begin
            changed_d = q_d ^ q_q;
        end else begin
            changed_d = ZERO_VAL;
        end
    end

    // State registers; reset wins over every other control on the same edge.
    always_ff @(posedge Ck) begin
        if (Reset) begin
            q_q       <= RESET_VAL;
            changed_q <= ZERO_VAL;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
        end
    end

    // Terminal count: flags that the coming edge will wrap the counter.
    always_comb begin
        Tc = 1'b0;
        if (En && (Mode == MODE_UP) && (q_q == ONES_VAL)) begin
            Tc = 1'b1;
        end else if (En && (Mode == MODE_DOWN) && (q_q == ZERO_VAL)) begin
            Tc = 1'b1;
        end else begin
            Tc = 1'b0;
        end
    end

    // Serial output taps the bit that is about to be shifted out.
    always_comb begin
        SerOut = q_q[0];
        if (Mode == MODE_SHL) begin
            SerOut = q_q[WIDTH-1];
        end else begin
            SerOut = q_q[0];
        end
    end

    assign Q       = q_q;
    assign Qn      = ~q_q;
    assign Changed = changed_q;

endmodule

// File: tb/tb_jk_universal_register.sv
// Directed testbench for jk_universal_register (WIDTH=8, RESET_VAL=0).
module tb_jk_universal_register;

    logic       Ck;
    logic       Reset;
    logic       En;
    logic [2:0] Mode;
    logic [7:0] J;
    logic [7:0] K;
    logic [7:0] D;
    logic       SerIn;
    logic [7:0] Q;
    logic [7:0] Qn;
    logic       SerOut;
    logic       Tc;
    logic [7:0] Changed;

    int n_checks;
    int n_fail;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_JK   = 3'b001;
    localparam logic [2:0] M_LOAD = 3'b010;
    localparam logic [2:0] M_SHL  = 3'b011;
    localparam logic [2:0] M_SHR  = 3'b100;
    localparam logic [2:0] M_UP   = 3'b101;
    localparam logic [2:0] M_DOWN = 3'b110;
    localparam logic [2:0] M_INV  = 3'b111;

    jk_universal_register #(
        .WIDTH    (8),
        .RESET_VAL(8'h00)
    ) dut (
        .Ck     (Ck),
        .Reset  (Reset),
        .En     (En),
        .Mode   (Mode),
        .J      (J),
        .K      (K),
        .D      (D),
        .SerIn  (SerIn),
        .Q      (Q),
        .Qn     (Qn),
        .SerOut (SerOut),
        .Tc     (Tc),
        .Changed(Changed)
    );

    initial Ck = 1'b0;
    always #5 Ck = ~Ck;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge Ck);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        En   = 1'b1;
        Mode = M_LOAD;
        D    = val;
        step();
    endtask

    task automatic test_reset();
        Reset = 1'b1; En = 1'b1; Mode = M_INV;
        step();
        n_checks++;
        if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want %h", Q, 8'h00); end
        n_checks++;
        if (Qn !== 8'hFF) begin n_fail++; $display("FAIL reset_qn: got %h want %h", Qn, 8'hFF); end
        n_checks++;
        if (Changed !== 8'h00) begin n_fail++; $display("FAIL reset_changed: got %h want %h", Changed, 8'h00); end
        Reset = 1'b0;
        load(8'h36);
        Mode = M_UP;
        step();
        n_checks++;
        if (Q !== 8'h37) begin n_fail++; $display("FAIL count_to_37: got %h want %h", Q, 8'h37); end
        Reset = 1'b1;
        step();
        n_checks++;
        if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_mid_count_q: got %h want %h", Q, 8'h00); end
        n_checks++;
        if (Changed !== 8'h00) begin n_fail++; $display("FAIL reset_mid_count_changed: got %h want %h", Changed, 8'h00); end
        Reset = 1'b0;
    endtask

    task automatic test_jk();
        load(8'hF0);
        Mode = M_JK; J = 8'hCC; K = 8'hAA;
        step();
        // (CC & ~F0) | (~AA & F0) = 0C | 50 = 5C
        n_checks++;
        if (Q !== 8'h5C) begin n_fail++; $display("FAIL jk1_q: got %h want %h", Q, 8'h5C); end
        n_checks++;
        if (Changed !== 8'hAC) begin n_fail++; $display("FAIL jk1_changed: got %h want %h", Changed, 8'hAC); end
        step();
        // (CC & ~5C) | (~AA & 5C) = 80 | 54 = D4
        n_checks++;
        if (Q !== 8'hD4) begin n_fail++; $display("FAIL jk2_q: got %h want %h", Q, 8'hD4); end
        n_checks++;
        if (Changed !== 8'h88) begin n_fail++; $display("FAIL jk2_changed: got %h want %h", Changed, 8'h88); end
    endtask

    task automatic test_count();
        load(8'hFE);
        Mode = M_UP;
        #1;
        n_checks++;
        if (Tc !== 1'b0) begin n_fail++; $display("FAIL tc_at_fe: got %b want %b", Tc, 1'b0); end
        step();
        n_checks++;
        if (Q !== 8'hFF) begin n_fail++; $display("FAIL up_to_ff: got %h want %h", Q, 8'hFF); end
        n_checks++;
        if (Tc !== 1'b1) begin n_fail++; $display("FAIL tc_up_ff: got %b want %b", Tc, 1'b1); end
        step();
        n_checks++;
        if (Q !== 8'h00) begin n_fail++; $display("FAIL up_wrap_q: got %h want %h", Q, 8'h00); end
        n_checks++;
        if (Tc !== 1'b0) begin n_fail++; $display("FAIL tc_up_after_wrap: got %b want %b", Tc, 1'b0); end
        n_checks++;
        if (Changed !== 8'hFF) begin n_fail++; $display("FAIL up_wrap_changed: got %h want %h", Changed, 8'hFF); end
        Mode = M_DOWN;
        #1;
        n_checks++;
        if (Tc !== 1'b1) begin n_fail++; $display("FAIL tc_down_zero: got %b want %b", Tc, 1'b1); end
        step();
        n_checks++;
        if (Q !== 8'hFF) begin n_fail++; $display("FAIL down_wrap_q: got %h want %h", Q, 8'hFF); end
        n_checks++;
        if (Tc !== 1'b0) begin n_fail++; $display("FAIL tc_down_ff: got %b want %b", Tc, 1'b0); end
        step();
        n_checks++;
        if (Q !== 8'hFE) begin n_fail++; $display("FAIL down_fe: got %h want %h", Q, 8'hFE); end
        n_checks++;
        if (Changed !== 8'h01) begin n_fail++; $display("FAIL down_fe_changed: got %h want %h", Changed, 8'h01); end
    endtask

    task automatic test_shift();
        load(8'h81);
        Mode = M_SHL; SerIn = 1'b0;
        #1;
        n_checks++;
        if (SerOut !== 1'b1) begin n_fail++; $display("FAIL serout_shl: got %b want %b", SerOut, 1'b1); end
        step();
        n_checks++;
        if (Q !== 8'h02) begin n_fail++; $display("FAIL shl_q: got %h want %h", Q, 8'h02); end
        Mode = M_SHR; SerIn = 1'b1;
        #1;
        n_checks++;
        if (SerOut !== 1'b0) begin n_fail++; $display("FAIL serout_shr: got %b want %b", SerOut, 1'b0); end
        step();
        n_checks++;
        if (Q !== 8'h81) begin n_fail++; $display("FAIL shr_q: got %h want %h", Q, 8'h81); end
        n_checks++;
        if (Changed !== 8'h83) begin n_fail++; $display("FAIL shr_changed: got %h want %h", Changed, 8'h83); end
        n_checks++;
        if (SerOut !== 1'b1) begin n_fail++; $display("FAIL serout_shr_lsb: got %b want %b", SerOut, 1'b1); end
    endtask

    task automatic test_enable();
        load(8'h5A);
        En = 1'b0; Mode = M_INV;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (Q !== 8'h5A) begin n_fail++; $display("FAIL en0_q[%0d]: got %h want %h", i, Q, 8'h5A); end
            n_checks++;
            if (Changed !== 8'h00) begin n_fail++; $display("FAIL en0_changed[%0d]: got %h want %h", i, Changed, 8'h00); end
            n_checks++;
            if (Tc !== 1'b0) begin n_fail++; $display("FAIL en0_tc[%0d]: got %b want %b", i, Tc, 1'b0); end
        end
        En = 1'b1;
        step();
        n_checks++;
        if (Q !== 8'hA5) begin n_fail++; $display("FAIL inv_q: got %h want %h", Q, 8'hA5); end
        n_checks++;
        if (Qn !== 8'h5A) begin n_fail++; $display("FAIL inv_qn: got %h want %h", Qn, 8'h5A); end
        n_checks++;
        if (Changed !== 8'hFF) begin n_fail++; $display("FAIL inv_changed: got %h want %h", Changed, 8'hFF); end
    endtask

    task automatic test_hold();
        load(8'h3C);
        Mode = M_HOLD;
        for (int i = 0; i < 4; i++) begin
            J = 8'($urandom); K = 8'($urandom); D = 8'($urandom); SerIn = 1'($urandom);
            step();
            n_checks++;
            if (Q !== 8'h3C) begin n_fail++; $display("FAIL hold_q[%0d]: got %h want %h", i, Q, 8'h3C); end
            n_checks++;
            if (Changed !== 8'h00) begin n_fail++; $display("FAIL hold_changed[%0d]: got %h want %h", i, Changed, 8'h00); end
        end
    endtask

    task automatic test_back_to_back();
        // Mid-cycle data changes only matter at the edge.
        Mode = M_LOAD; D = 8'h11;
        #2; D = 8'h22;
        #2; D = 8'h33;
        step();
        n_checks++;
        if (Q !== 8'h33) begin n_fail++; $display("FAIL load_last_d: got %h want %h", Q, 8'h33); end
        Mode = M_UP;
        step();
        Mode = M_INV;
        step();
        Mode = M_DOWN;
        step();
        // 33 -> 34 -> CB -> CA
        n_checks++;
        if (Q !== 8'hCA) begin n_fail++; $display("FAIL b2b_q: got %h want %h", Q, 8'hCA); end
        n_checks++;
        if (Changed !== 8'h01) begin n_fail++; $display("FAIL b2b_changed: got %h want %h", Changed, 8'h01); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset = 1'b1; En = 1'b0; Mode = M_HOLD;
        J = 8'h00; K = 8'h00; D = 8'h00; SerIn = 1'b0;
        #2;
        test_reset();
        test_jk();
        test_count();
        test_shift();
        test_enable();
        test_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
